cpu_0_mult_arbiter: RTL and testbench
=====================================

# cpu_0_mult_arbiter

Shares the single pipelined 32-bit multiplier cell (`cpu_0_mult_cell`, low 32 bits of an unsigned 32x32 product) between `NUM_REQ` requesters using valid/ready handshakes. Requests are granted round-robin, and each request's tag is tracked through the cell's fixed latency. Results are buffered in a small in-order response FIFO and returned to the owning requester. The block sits between the cell and its clients (CPU custom-instruction path, audio DSP helpers).

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, 1..8.
- `LATENCY`, 1: cell register stages from operands to `mul_result`.
- `FIFO_DEPTH`, 3: response FIFO entries. Must be >= `LATENCY`+2 for full throughput.

Ports:
- `clk`  in  1: single clock. All logic is rising-edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ: request pending, one bit per requester.
- `req_ready`  out  NUM_REQ: request accepted this cycle. At most one bit is high.
- `req_src1`  in  NUM_REQ*32: operand A, requester i in bits [32i+31:32i].
- `req_src2`  in  NUM_REQ*32: operand B, same packing.
- `mul_src1`  out  32: operand A to the cell.
- `mul_src2`  out  32: operand B to the cell.
- `mul_result`  in  32: cell product, valid `LATENCY` cycles after the operands.
- `rsp_valid`  out  NUM_REQ: one-hot. Asserted to the owner of the FIFO head.
- `rsp_ready`  in  NUM_REQ: owner accepts the response.
- `rsp_result`  out  32: product at the FIFO head.
- `busy`  out  1: any operation in flight or buffered.

## Operation
- **Credit.** `can_issue` = (`inflight_cnt` + `fifo_cnt` < `FIFO_DEPTH`). Both counts are registered values; a pop in the same cycle is not credited, so there is no `rsp_ready`->`req_ready` path.
- **Arbitration.** Round-robin. `rr_ptr` holds the index of the last grant. The winner is the first requester with `req_valid` high, searching from `rr_ptr`+1 with wrap-around. `req_ready[winner]` = `can_issue`. `rr_ptr` updates only on an issue (`req_valid` & `req_ready`).
- **Requester rule.** Once `req_valid` is asserted, the requester holds it and its operands stable until accepted. The arbiter does not check this.
- **Operand mux.** `mul_src1`/`mul_src2` = the winner's operands when `can_issue` and any `req_valid` is high; otherwise 0. The mux is combinational.
- **Tag pipeline.** `LATENCY`-stage shift register of {valid, tag}, where tag is `$clog2(NUM_REQ)` bits (minimum 1). Stage 0 loads {issue, winner}. `inflight_cnt` is the popcount of the valid bits.
- **Capture.** When the last stage is valid, {tag, `mul_result`} is pushed into the FIFO at the end of that cycle.
- **Response.** FIFO non-empty -> `rsp_valid[head.tag]` = 1 and `rsp_result` = `head.data`. Pop on `rsp_valid[head.tag]` & `rsp_ready[head.tag]`.
- **Ordering.** Responses are strictly in issue order. A stalled owner blocks all later responses (head-of-line blocking by design).
- **Push and pop together.** A simultaneous push and pop leaves `fifo_cnt` unchanged. The credit rule guarantees a push is never made into a full FIFO.
- **Overflow check.** Overflow is an assertion failure in simulation.
- **`busy`** = (`inflight_cnt` != 0) | (`fifo_cnt` != 0).

## Timing
- **Reset values.** `req_ready` = 0, `rsp_valid` = 0, `rsp_result` = 0, `mul_src1`/`mul_src2` = 0, `busy` = 0. `rr_ptr` resets to `NUM_REQ`-1, so requester 0 has first priority.
- **Latency.** Issue at edge t -> push at the edge ending cycle t+`LATENCY` -> `rsp_valid` high from cycle t+`LATENCY`+1.
- **Throughput.** With `FIFO_DEPTH` >= `LATENCY`+2 and responses always accepted, one issue per cycle is sustained.
- **Reset mid-operation.** In-flight tags, FIFO contents and `rr_ptr` are discarded immediately. No response is produced for those requests. The cell is cleared by the same reset.
- **`NUM_REQ`=1.** The arbiter degenerates to credit gating only. Tag is constant 0.

## Structure
- **Package `cpu_0_mult_pkg`.**
  - Constants `MUL_DATA_W` = 32 and `MUL_CELL_LATENCY` = 1 (matches the cell).
  - Function `tag_w(n)` = max(1, `$clog2(n)`).
  - Typedef `mul_rsp_t` = {tag, data}.
- **Sub-module `cpu_0_mult_rsp_fifo`.** Synchronous FIFO of `mul_rsp_t` with `FIFO_DEPTH` entries. Pointers wrap at `FIFO_DEPTH` (a non-power-of-2 depth is legal). Exposes `count`.
- **Top level.** Contains the arbiter, `rr_ptr`, the tag shift register and the credit logic.

## Test plan
1. **Single request.** Reset, then requester 0 issues 3 x 5 -> `rsp_valid` = 01 two cycles after issue, `rsp_result` = 15.
2. **Round-robin.** Both requesters hold valid continuously, all `rsp_ready` = 1 -> grants alternate 0,1,0,1. Requester 1 issuing 0xFFFFFFFF x 2 gets 0xFFFFFFFE. One issue per cycle.
3. **Backpressure.** Requester 0 holds `rsp_ready` = 0 -> exactly 3 issues are accepted, then `req_ready` = 0. Releasing `rsp_ready` drains the responses in order and issuing resumes.
4. **Head-of-line blocking.** Issue order 0 then 1, and requester 0 stalls for 4 cycles -> requester 1 sees no `rsp_valid` until requester 0's response pops.
5. **Reset mid-operation.** Assert `reset_n` = 0 with 2 operations in flight -> all outputs at reset values in the same cycle. After release, no stale response appears and requester 0 wins first.
6. **Operand hold.** Requester 1 is valid while requester 0 is granted -> requester 1's operands are not presented to the cell until its grant cycle.

Source files
------------

// File: rtl/cpu_0_mult_pkg.sv
// cpu_0_mult_pkg: shared constants and types for the multiplier arbiter and its response FIFO
package cpu_0_mult_pkg;
  localparam int MUL_DATA_W       = 32;
  localparam int MUL_CELL_LATENCY = 1;
  localparam int MUL_TAG_MAX_W    = 3;

  function automatic int tag_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [MUL_TAG_MAX_W-1:0] tag;
    logic [MUL_DATA_W-1:0]    data;
  } mul_rsp_t;
endpackage

// File: rtl/cpu_0_mult_rsp_fifo.sv
// cpu_0_mult_rsp_fifo: in-order response buffer, pointers wrap at DEPTH so any depth works
module cpu_0_mult_rsp_fifo
  import cpu_0_mult_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push_i,
  input  mul_rsp_t                   push_data_i,
  input  logic                       pop_i,
  output mul_rsp_t                   head_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mul_rsp_t      mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // next pointers and occupancy; push and pop together leave the count unchanged
  always_comb begin
    wr_ptr_d = push_i ? bump(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_i ? bump(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(push_i) - CW'(pop_i);
    head_o   = mem_q[rd_ptr_q];
    empty_o  = (count_q == '0);
    count_o  = count_q;
  end

  // pointer and count state, cleared by reset so buffered results are dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage needs no reset: the count alone decides what is valid
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assert property (@(posedge clk) disable iff (!reset_n) push_i |-> (count_q != CW'(DEPTH)));
endmodule

// File: rtl/cpu_0_mult_arbiter.sv
// cpu_0_mult_arbiter: round-robin sharing of the pipelined multiplier cell between requesters
module cpu_0_mult_arbiter
  import cpu_0_mult_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int LATENCY    = MUL_CELL_LATENCY,
  parameter int FIFO_DEPTH = 3
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*MUL_DATA_W-1:0] req_src1,
  input  logic [NUM_REQ*MUL_DATA_W-1:0] req_src2,
  output logic [MUL_DATA_W-1:0]         mul_src1,
  output logic [MUL_DATA_W-1:0]         mul_src2,
  input  logic [MUL_DATA_W-1:0]         mul_result,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [MUL_DATA_W-1:0]         rsp_result,
  output logic                          busy
);
  localparam int TW  = tag_w(NUM_REQ);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int ICW = $clog2(LATENCY + 1);

  logic [TW-1:0]              rr_ptr_q, rr_ptr_d, winner;
  logic [LATENCY-1:0]         vld_q, vld_d;
  logic [LATENCY-1:0][TW-1:0] tag_q, tag_d;
  logic [ICW-1:0]             inflight_cnt;
  logic [FCW-1:0]             fifo_cnt;
  logic                       any_valid, can_issue, issue, fifo_empty, pop;
  mul_rsp_t                   fifo_head, fifo_push_data;

  function automatic int wrap(input int i);
    return (i >= NUM_REQ) ? i - NUM_REQ : i;
  endfunction

  // round-robin search from just after the last grant; descending loop lets the nearest candidate win
  always_comb begin
    winner    = rr_ptr_q;
    any_valid = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[wrap(int'(rr_ptr_q) + k)]) begin
        winner    = TW'(wrap(int'(rr_ptr_q) + k));
        any_valid = 1'b1;
      end
    end
  end

  // products still inside the cell, counted from the tag pipeline valid bits
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < LATENCY; i++) inflight_cnt = inflight_cnt + ICW'(vld_q[i]);
  end

  // credit from registered counts only, so a same-cycle pop never feeds req_ready; held off during reset
  always_comb begin
    can_issue = reset_n && ((int'(inflight_cnt) + int'(fifo_cnt)) < FIFO_DEPTH);
    issue     = can_issue && any_valid;
    req_ready = issue ? (NUM_REQ'(1) << winner) : '0;
    mul_src1  = issue ? req_src1[int'(winner)*MUL_DATA_W +: MUL_DATA_W] : '0;
    mul_src2  = issue ? req_src2[int'(winner)*MUL_DATA_W +: MUL_DATA_W] : '0;
    rr_ptr_d  = issue ? winner : rr_ptr_q;
    vld_d     = LATENCY'({vld_q, issue});
    tag_d     = (LATENCY*TW)'({tag_q, winner});
  end

  // FIFO head goes to its owner only; a stalled owner blocks everything behind it
  always_comb begin
    fifo_push_data = {MUL_TAG_MAX_W'(tag_q[LATENCY-1]), mul_result};
    rsp_valid      = fifo_empty ? '0 : (NUM_REQ'(1) << fifo_head.tag);
    rsp_result     = fifo_empty ? '0 : fifo_head.data;
    pop            = !fifo_empty && rsp_ready[fifo_head.tag];
    busy           = (vld_q != '0) || (fifo_cnt != '0);
  end

  // grant pointer and tag pipeline; reset drops every in-flight tag and restarts priority at requester 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= TW'(NUM_REQ - 1);
      vld_q    <= '0;
      tag_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      vld_q    <= vld_d;
      tag_q    <= tag_d;
    end
  end

  cpu_0_mult_rsp_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (vld_q[LATENCY-1]),
    .push_data_i(fifo_push_data),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .empty_o    (fifo_empty),
    .count_o    (fifo_cnt)
  );
endmodule

// File: tb/tb_cpu_0_mult_arbiter.sv
// tb_cpu_0_mult_arbiter: scoreboard bench with a one-stage cell model and directed vectors
module tb_cpu_0_mult_arbiter;
  typedef struct packed { logic [31:0] a; logic [31:0] b; logic [31:0] p; } vec_t;
  typedef struct packed { logic [7:0] tag; logic [31:0] data; } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [63:0] req_src1, req_src2;
  logic [31:0] mul_src1, mul_src2, mul_result, rsp_result;
  logic        busy;

  vec_t vq0[$], vq1[$];
  exp_t sb[$];
  int   glog[$], gcyc[$];
  int   cyc = 0, n_chk = 0, n_fail = 0;
  logic [1:0] took;
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpu_0_mult_arbiter #(
    .NUM_REQ(2), .LATENCY(1), .FIFO_DEPTH(3)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src1(req_src1), .req_src2(req_src2),
    .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .busy(busy)
  );

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) mul_result <= '0;
    else mul_result <= mul_src1 * mul_src2;
  end

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
    return {a, b, p};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_begin();
    reset_n = 1'b0;
    sb.delete(); vq0.delete(); vq1.delete(); glog.delete(); gcyc.delete();
  endtask

  task automatic reset_end();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    while ((sb.size() + vq0.size() + vq1.size()) != 0 && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk("drain_pending", sb.size() + vq0.size() + vq1.size(), 0);
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 1'b0);
  endtask

  // driver: records issues at the negedge, advances each requester's vector list after the edge
  initial begin
    req_valid = '0; req_src1 = '0; req_src2 = '0;
    forever begin
      @(negedge clk);
      took = '0;
      if (reset_n) begin
        if (req_valid[0] && req_ready[0] && vq0.size() > 0) begin
          took[0] = 1'b1; sb.push_back({8'd0, vq0[0].p}); glog.push_back(0); gcyc.push_back(cyc);
        end
        if (req_valid[1] && req_ready[1] && vq1.size() > 0) begin
          took[1] = 1'b1; sb.push_back({8'd1, vq1[0].p}); glog.push_back(1); gcyc.push_back(cyc);
        end
      end
      @(posedge clk);
      #1;
      if (took[0] && vq0.size() > 0) void'(vq0.pop_front());
      if (took[1] && vq1.size() > 0) void'(vq1.pop_front());
      req_valid = {vq1.size() > 0, vq0.size() > 0};
      req_src1  = {vq1.size() > 0 ? vq1[0].a : 32'd0, vq0.size() > 0 ? vq0[0].a : 32'd0};
      req_src2  = {vq1.size() > 0 ? vq1[0].b : 32'd0, vq0.size() > 0 ? vq0[0].b : 32'd0};
    end
  end

  // monitor: every accepted response must be the oldest outstanding one
  always @(negedge clk) begin
    if (reset_n) begin
      for (int i = 0; i < 2; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL stale_rsp: requester %0d got 0x%0h, want no response", i, rsp_result);
          end else begin
            mon_e = sb.pop_front();
            chk("rsp_owner", i, 32'(mon_e.tag));
            chk("rsp_data", rsp_result, mon_e.data);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before %0d", 100000);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    rsp_ready = '0;
    vq0.push_back(mk(32'd3, 32'd5, 32'd15));
    @(negedge clk);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_mul_src1", mul_src1, 32'd0);
    chk("rst_mul_src2", mul_src2, 32'd0);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_busy", busy, 1'b0);
    reset_begin();
    reset_end();

    // single request: response two cycles after issue
    rsp_ready = 2'b11;
    vq0.push_back(mk(32'd3, 32'd5, 32'd15));
    @(negedge clk);
    chk("single_ready", req_ready, 2'b01);
    chk("single_src1", mul_src1, 32'd3);
    chk("single_src2", mul_src2, 32'd5);
    @(negedge clk);
    chk("single_no_rsp_yet", rsp_valid, 2'b00);
    chk("single_busy", busy, 1'b1);
    @(negedge clk);
    chk("single_rsp_valid", rsp_valid, 2'b01);
    chk("single_rsp_result", rsp_result, 32'd15);
    @(negedge clk);
    chk("single_idle", busy, 1'b0);

    // round-robin at full rate
    reset_begin(); reset_end();
    rsp_ready = 2'b11;
    vq0.push_back(mk(32'd2, 32'd3, 32'd6));
    vq0.push_back(mk(32'd10, 32'd10, 32'd100));
    vq0.push_back(mk(32'h10000, 32'h10000, 32'h0));
    vq0.push_back(mk(32'h12345678, 32'd1, 32'h12345678));
    vq1.push_back(mk(32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE));
    vq1.push_back(mk(32'h80000000, 32'd3, 32'h80000000));
    vq1.push_back(mk(32'd1000, 32'd1000, 32'd1000000));
    vq1.push_back(mk(32'hFFFF, 32'hFFFF, 32'hFFFE0001));
    drain(60);
    chk("rr_grant_count", glog.size(), 8);
    for (int k = 0; k < glog.size(); k++) chk("rr_grant_order", glog[k], k % 2);
    if (gcyc.size() > 0) chk("rr_back_to_back", gcyc[gcyc.size()-1] - gcyc[0], gcyc.size() - 1);

    // backpressure: credit stops issue after three
    reset_begin(); reset_end();
    rsp_ready = 2'b10;
    vq0.push_back(mk(32'd4, 32'd4, 32'd16));
    vq0.push_back(mk(32'd5, 32'd6, 32'd30));
    vq0.push_back(mk(32'd7, 32'd8, 32'd56));
    vq0.push_back(mk(32'd9, 32'd9, 32'd81));
    vq0.push_back(mk(32'd11, 32'd11, 32'd121));
    repeat (6) @(negedge clk);
    chk("bp_issued", glog.size(), 3);
    chk("bp_req_ready", req_ready, 2'b00);
    chk("bp_rsp_valid", rsp_valid, 2'b01);
    chk("bp_head", rsp_result, 32'd16);
    chk("bp_busy", busy, 1'b1);
    @(posedge clk);
    #1 rsp_ready = 2'b11;
    drain(40);
    chk("bp_resumed", glog.size(), 5);

    // head-of-line blocking
    reset_begin(); reset_end();
    rsp_ready = 2'b10;
    vq0.push_back(mk(32'd6, 32'd7, 32'd42));
    vq1.push_back(mk(32'd8, 32'd9, 32'd72));
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("hol_r1_blocked", rsp_valid[1], 1'b0);
      if (k >= 3) chk("hol_r0_head", rsp_valid, 2'b01);
    end
    @(posedge clk);
    #1 rsp_ready = 2'b11;
    @(negedge clk);
    chk("hol_r0_release", rsp_valid, 2'b01);
    @(negedge clk);
    chk("hol_r1_valid", rsp_valid, 2'b10);
    chk("hol_r1_result", rsp_result, 32'd72);
    drain(20);

    // reset with work in flight
    reset_begin(); reset_end();
    rsp_ready = 2'b00;
    vq0.push_back(mk(32'd3, 32'd3, 32'd9));
    vq0.push_back(mk(32'd5, 32'd2, 32'd10));
    vq1.push_back(mk(32'd4, 32'd4, 32'd16));
    @(negedge clk);
    chk("mid_grant0", req_ready, 2'b01);
    @(negedge clk);
    chk("mid_grant1", req_ready, 2'b10);
    @(negedge clk);
    chk("mid_grant2", req_ready, 2'b01);
    chk("mid_busy", busy, 1'b1);
    #1 reset_begin();
    #1;
    chk("mid_rst_req_ready", req_ready, 2'b00);
    chk("mid_rst_rsp_valid", rsp_valid, 2'b00);
    chk("mid_rst_rsp_result", rsp_result, 32'd0);
    chk("mid_rst_src1", mul_src1, 32'd0);
    chk("mid_rst_src2", mul_src2, 32'd0);
    chk("mid_rst_busy", busy, 1'b0);
    reset_end();
    rsp_ready = 2'b11;
    vq0.push_back(mk(32'd5, 32'd5, 32'd25));
    vq1.push_back(mk(32'd6, 32'd6, 32'd36));
    @(negedge clk);
    chk("post_rst_first", req_ready, 2'b01);
    drain(20);

    // operand hold: the waiting requester never reaches the cell early
    reset_begin(); reset_end();
    rsp_ready = 2'b11;
    vq0.push_back(mk(32'h1111, 32'd2, 32'h2222));
    vq1.push_back(mk(32'hABCD, 32'h10, 32'hABCD0));
    @(negedge clk);
    chk("hold_ready0", req_ready, 2'b01);
    chk("hold_src1_r0", mul_src1, 32'h1111);
    chk("hold_src2_r0", mul_src2, 32'd2);
    @(negedge clk);
    chk("hold_ready1", req_ready, 2'b10);
    chk("hold_src1_r1", mul_src1, 32'hABCD);
    chk("hold_src2_r1", mul_src2, 32'h10);
    drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
